// File: rtl/mfc_mode_sched_pkg.sv
// Shared encodings for the multi-function clock mode scheduler:
// mode values, button bit positions, editable field indices and button arbitration.
package mfc_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL  = 2'b00,
        MODE_CLK_SET = 2'b01,
        MODE_ALM_SET = 2'b10,
        MODE_SW      = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        BTN_UP     = 3'd0,
        BTN_DOWN   = 3'd1,
        BTN_LEFT   = 3'd2,
        BTN_RIGHT  = 3'd3,
        BTN_CENTER = 3'd4
    } btn_e;

    typedef enum logic [1:0] {
        FIELD_SEC = 2'd0,
        FIELD_MIN = 2'd1,
        FIELD_HR  = 2'd2
    } field_e;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_UP,
        ACT_DOWN,
        ACT_RIGHT,
        ACT_LEFT,
        ACT_CENTER
    } act_e;

    localparam int NUM_BTN = 5;

    // Only one button acts per cycle; right outranks left so a rocked d-pad moves forward.
    function automatic act_e btn_priority(input logic [NUM_BTN-1:0] btn);
        if (btn[BTN_UP])     return ACT_UP;
        if (btn[BTN_DOWN])   return ACT_DOWN;
        if (btn[BTN_RIGHT])  return ACT_RIGHT;
        if (btn[BTN_LEFT])   return ACT_LEFT;
        if (btn[BTN_CENTER]) return ACT_CENTER;
        return ACT_NONE;
    endfunction

endpackage

// File: rtl/mfc_mode_sched_if.sv
// Signal bundle between the switch/button front end (master) and the mode scheduler (slave).
interface mfc_mode_sched_if;

    logic       sw_clk_set;
    logic       sw_alm_set;
    logic       sw_stopwatch;
    logic [4:0] btn_pulse;
    logic       tick_1hz;
    logic       alarm_match;

    logic [1:0] mode;
    logic [1:0] cursor;
    logic       set_inc;
    logic       set_dec;
    logic       set_tgt;
    logic       sw_run;
    logic       sw_clear;
    logic       alarm_armed;
    logic       alarm_ring;

    modport master (
        output sw_clk_set, sw_alm_set, sw_stopwatch, btn_pulse, tick_1hz, alarm_match,
        input  mode, cursor, set_inc, set_dec, set_tgt, sw_run, sw_clear,
               alarm_armed, alarm_ring
    );

    modport slave (
        input  sw_clk_set, sw_alm_set, sw_stopwatch, btn_pulse, tick_1hz, alarm_match,
        output mode, cursor, set_inc, set_dec, set_tgt, sw_run, sw_clear,
               alarm_armed, alarm_ring
    );

endinterface

// File: rtl/mfc_mode_sched_alarm_ringer.sv
// Alarm ringer: rising-edge detect on the time match, ring flag and a seconds
// down-counter that silences the alarm after RING_SEC ticks. Built only with MFC_ALARM_EN.
module mfc_alarm_ringer #(
    parameter int RING_SEC = 30
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic armed_i,
    input  logic match_i,
    input  logic block_i,
    input  logic tick_i,
    input  logic btn_any_i,
    output logic ring_o
);

    localparam int CW = $clog2(RING_SEC + 1);
    localparam logic [CW-1:0] RING_LOAD = CW'(RING_SEC);

    logic          match_q;
    logic          ring_q;
    logic [CW-1:0] cnt_q;
    logic          start_d;

    assign start_d = armed_i && match_i && !match_q && !block_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            match_q <= 1'b0;
            ring_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            match_q <= match_i;
            if (btn_any_i || !armed_i) begin
                ring_q <= 1'b0;
            end else if (start_d) begin
                ring_q <= 1'b1;
                cnt_q  <= RING_LOAD;
            end else if (ring_q && tick_i) begin
                if (cnt_q == CW'(1)) ring_q <= 1'b0;
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign ring_o = ring_q;

endmodule

// File: rtl/mfc_mode_sched.sv
// Mode scheduler: switch-selected mode register, set-mode field cursor and command strobes.
// Build option MFC_ALARM_EN adds the alarm-set mode, arm toggle and ringer.
//
// state        | meaning
// MODE_NORMAL  | time of day; center toggles alarm arm
// MODE_CLK_SET | up/down strobe clock field, left/right move cursor
// MODE_ALM_SET | same as clock set, targeting alarm registers
// MODE_SW      | stopwatch; center run/stop, down clears when stopped
module mfc_mode_sched
    import mfc_pkg::*;
#(
    parameter int NUM_FIELDS = 3,
    parameter int RING_SEC   = 30
) (
    input  logic            MCLK,
    input  logic            RST,
    mfc_mode_sched_if.slave sched_if
);

    localparam logic [1:0] CUR_LAST = 2'(NUM_FIELDS - 1);

    mode_e      mode_q;
    mode_e      mode_d;
    logic [1:0] cursor_q;
    logic       set_inc_q;
    logic       set_dec_q;
    logic       set_tgt_q;
    logic       sw_run_q;
    logic       sw_clear_q;
    logic       armed_q;
    logic       ring;
    logic       btn_any;
    act_e       act;

    assign btn_any = |sched_if.btn_pulse;
    assign act     = btn_priority(sched_if.btn_pulse);

`ifdef MFC_ALARM_EN
    always_comb begin
        mode_d = MODE_NORMAL;
        if (sched_if.sw_clk_set)        mode_d = MODE_CLK_SET;
        else if (sched_if.sw_alm_set)   mode_d = MODE_ALM_SET;
        else if (sched_if.sw_stopwatch) mode_d = MODE_SW;
    end

    mfc_alarm_ringer #(
        .RING_SEC (RING_SEC)
    ) u_ringer (
        .clk_i     (MCLK),
        .rst_i     (RST),
        .armed_i   (armed_q),
        .match_i   (sched_if.alarm_match),
        .block_i   (mode_q == MODE_ALM_SET),
        .tick_i    (sched_if.tick_1hz),
        .btn_any_i (btn_any),
        .ring_o    (ring)
    );
`else
    always_comb begin
        mode_d = MODE_NORMAL;
        if (sched_if.sw_clk_set)        mode_d = MODE_CLK_SET;
        else if (sched_if.sw_stopwatch) mode_d = MODE_SW;
    end

    assign ring = 1'b0;

    logic unused_alarm;
    assign unused_alarm = ^{sched_if.sw_alm_set, sched_if.alarm_match, sched_if.tick_1hz};
`endif

    always_ff @(posedge MCLK) begin
        if (RST) begin
            mode_q     <= MODE_NORMAL;
            cursor_q   <= FIELD_SEC;
            set_inc_q  <= 1'b0;
            set_dec_q  <= 1'b0;
            set_tgt_q  <= 1'b0;
            sw_run_q   <= 1'b0;
            sw_clear_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            set_inc_q  <= 1'b0;
            set_dec_q  <= 1'b0;
            sw_clear_q <= 1'b0;
            mode_q     <= mode_d;
`ifdef MFC_ALARM_EN
            set_tgt_q  <= (mode_d == MODE_ALM_SET);
`endif
            // A pulse coinciding with a mode change or silencing the alarm does nothing else.
            if (mode_d != mode_q) begin
                if (mode_d == MODE_CLK_SET || mode_d == MODE_ALM_SET) cursor_q <= FIELD_SEC;
            end else if (!(ring && btn_any)) begin
                case (mode_q)
                    MODE_CLK_SET, MODE_ALM_SET: begin
                        case (act)
                            ACT_UP:    set_inc_q <= 1'b1;
                            ACT_DOWN:  set_dec_q <= 1'b1;
                            ACT_RIGHT: cursor_q  <= (cursor_q == CUR_LAST) ? 2'd0 : cursor_q + 2'd1;
                            ACT_LEFT:  cursor_q  <= (cursor_q == 2'd0) ? CUR_LAST : cursor_q - 2'd1;
                            default:   ;
                        endcase
                    end
                    MODE_SW: begin
                        if (act == ACT_CENTER)                sw_run_q   <= !sw_run_q;
                        else if (act == ACT_DOWN && !sw_run_q) sw_clear_q <= 1'b1;
                    end
                    default: begin
`ifdef MFC_ALARM_EN
                        if (act == ACT_CENTER) armed_q <= !armed_q;
`endif
                    end
                endcase
            end
        end
    end

    assign sched_if.mode        = mode_q;
    assign sched_if.cursor      = cursor_q;
    assign sched_if.set_inc     = set_inc_q;
    assign sched_if.set_dec     = set_dec_q;
    assign sched_if.set_tgt     = set_tgt_q;
    assign sched_if.sw_run      = sw_run_q;
    assign sched_if.sw_clear    = sw_clear_q;
    assign sched_if.alarm_armed = armed_q;
    assign sched_if.alarm_ring  = ring;

endmodule

// File: tb/tb_mfc_mode_sched.sv
// Directed self-checking bench for mfc_mode_sched; expectations follow the alarm build option.
`timescale 1ns/1ps
module tb_mfc_mode_sched;

`ifdef MFC_ALARM_EN
    localparam bit ALM = 1'b1;
`else
    localparam bit ALM = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mfc_mode_sched_if bus ();

    mfc_mode_sched #(
        .NUM_FIELDS (3),
        .RING_SEC   (30)
    ) dut (
        .MCLK     (clk),
        .RST      (rst),
        .sched_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] b);
        bus.btn_pulse = b;
        @(posedge clk);
        #1;
        bus.btn_pulse = '0;
    endtask

    function automatic logic [10:0] all_outs();
        return {bus.mode, bus.cursor, bus.set_inc, bus.set_dec, bus.set_tgt,
                bus.sw_run, bus.sw_clear, bus.alarm_armed, bus.alarm_ring};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.btn_pulse = 5'b10001;
        repeat (3) step();
        bus.btn_pulse = '0;
        checks++;
        if (all_outs() !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", all_outs(), 11'd0);
        end
        rst = 1'b0;
        step();
        press(5'b10000);
        checks++;
        if (bus.alarm_armed !== ALM) begin
            failures++;
            $display("FAIL arm_toggle got=%b exp=%b", bus.alarm_armed, ALM);
        end
    endtask

    task automatic test_cursor_wrap();
        logic [1:0] exp_r [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
        logic [1:0] exp_l [2] = '{2'd0, 2'd2};
        bus.sw_clk_set = 1'b1;
        step();
        checks++;
        if (bus.mode !== 2'b01 || bus.cursor !== 2'd0) begin
            failures++;
            $display("FAIL enter_clk_set mode=%b cursor=%0d exp mode=01 cursor=0", bus.mode, bus.cursor);
        end
        for (int i = 0; i < 4; i++) begin
            press(5'b01000);
            checks++;
            if (bus.cursor !== exp_r[i]) begin
                failures++;
                $display("FAIL cursor_right[%0d] got=%0d exp=%0d", i, bus.cursor, exp_r[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            press(5'b00100);
            checks++;
            if (bus.cursor !== exp_l[i]) begin
                failures++;
                $display("FAIL cursor_left[%0d] got=%0d exp=%0d", i, bus.cursor, exp_l[i]);
            end
        end
    endtask

    task automatic test_inc_target();
        press(5'b00001);
        checks++;
        if ({bus.set_inc, bus.set_dec, bus.set_tgt} !== 3'b100) begin
            failures++;
            $display("FAIL clk_inc got inc/dec/tgt=%b exp=100", {bus.set_inc, bus.set_dec, bus.set_tgt});
        end
        step();
        checks++;
        if (bus.set_inc !== 1'b0) begin
            failures++;
            $display("FAIL inc_one_cycle got=%b exp=0", bus.set_inc);
        end
        press(5'b01001);
        checks++;
        if (bus.set_inc !== 1'b1 || bus.cursor !== 2'd2) begin
            failures++;
            $display("FAIL simul_up_right inc=%b cursor=%0d exp inc=1 cursor=2", bus.set_inc, bus.cursor);
        end
        press(5'b00011);
        checks++;
        if ({bus.set_inc, bus.set_dec} !== 2'b10) begin
            failures++;
            $display("FAIL simul_up_down got inc/dec=%b exp=10", {bus.set_inc, bus.set_dec});
        end
        press(5'b01010);
        checks++;
        if (bus.set_dec !== 1'b1 || bus.cursor !== 2'd2) begin
            failures++;
            $display("FAIL simul_down_right dec=%b cursor=%0d exp dec=1 cursor=2", bus.set_dec, bus.cursor);
        end
        bus.sw_clk_set = 1'b0;
        bus.sw_alm_set = 1'b1;
        step();
        checks++;
        if (bus.mode !== (ALM ? 2'b10 : 2'b00) || bus.cursor !== (ALM ? 2'd0 : 2'd2)) begin
            failures++;
            $display("FAIL enter_alm_set mode=%b cursor=%0d exp mode=%b cursor=%0d",
                     bus.mode, bus.cursor, (ALM ? 2'b10 : 2'b00), (ALM ? 2'd0 : 2'd2));
        end
        press(5'b00010);
        checks++;
        if (bus.set_dec !== ALM || bus.set_tgt !== ALM) begin
            failures++;
            $display("FAIL alm_dec dec=%b tgt=%b exp=%b", bus.set_dec, bus.set_tgt, ALM);
        end
        press(5'b01000);
        checks++;
        if (bus.cursor !== (ALM ? 2'd1 : 2'd2)) begin
            failures++;
            $display("FAIL alm_cursor got=%0d exp=%0d", bus.cursor, (ALM ? 2'd1 : 2'd2));
        end
    endtask

    task automatic test_switch_change();
        bus.sw_alm_set = 1'b0;
        bus.sw_clk_set = 1'b1;
        bus.btn_pulse  = 5'b00001;
        step();
        bus.btn_pulse  = '0;
        checks++;
        if (bus.mode !== 2'b01 || bus.set_inc !== 1'b0 || bus.cursor !== 2'd0) begin
            failures++;
            $display("FAIL change_discard mode=%b inc=%b cursor=%0d exp 01/0/0", bus.mode, bus.set_inc, bus.cursor);
        end
        press(5'b01000);
        checks++;
        if (bus.cursor !== 2'd1) begin
            failures++;
            $display("FAIL after_change_right got=%0d exp=1", bus.cursor);
        end
    endtask

    task automatic test_priority();
        bus.sw_stopwatch = 1'b1;
        step();
        checks++;
        if (bus.mode !== 2'b01) begin
            failures++;
            $display("FAIL prio_clk_over_sw got=%b exp=01", bus.mode);
        end
        bus.sw_clk_set = 1'b0;
        bus.sw_alm_set = 1'b1;
        step();
        checks++;
        if (bus.mode !== (ALM ? 2'b10 : 2'b11)) begin
            failures++;
            $display("FAIL prio_alm_over_sw got=%b exp=%b", bus.mode, (ALM ? 2'b10 : 2'b11));
        end
        bus.sw_alm_set = 1'b0;
        step();
        checks++;
        if (bus.mode !== 2'b11) begin
            failures++;
            $display("FAIL prio_sw got=%b exp=11", bus.mode);
        end
    endtask

    task automatic test_stopwatch();
        logic [4:0] btn   [7] = '{5'b10000, 5'b00010, 5'b10000, 5'b00010, 5'b10010, 5'b10001, 5'b10000};
        logic [1:0] exp_o [7] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
        for (int i = 0; i < 7; i++) begin
            press(btn[i]);
            checks++;
            if ({bus.sw_run, bus.sw_clear} !== exp_o[i]) begin
                failures++;
                $display("FAIL sw_seq[%0d] btn=%b got run/clr=%b exp=%b", i, btn[i], {bus.sw_run, bus.sw_clear}, exp_o[i]);
            end
        end
        bus.sw_stopwatch = 1'b0;
        repeat (4) step();
        checks++;
        if (bus.mode !== 2'b00 || bus.sw_run !== 1'b1 || bus.sw_clear !== 1'b0) begin
            failures++;
            $display("FAIL sw_background mode=%b run=%b clr=%b exp 00/1/0", bus.mode, bus.sw_run, bus.sw_clear);
        end
    endtask

    task automatic test_alarm();
        bus.alarm_match = 1'b1;
        step();
        checks++;
        if (bus.alarm_ring !== ALM) begin
            failures++;
            $display("FAIL ring_start got=%b exp=%b", bus.alarm_ring, ALM);
        end
        for (int i = 0; i < 29; i++) begin
            bus.tick_1hz = 1'b1;
            step();
            bus.tick_1hz = 1'b0;
            step();
        end
        checks++;
        if (bus.alarm_ring !== ALM) begin
            failures++;
            $display("FAIL ring_29_ticks got=%b exp=%b", bus.alarm_ring, ALM);
        end
        bus.tick_1hz = 1'b1;
        step();
        bus.tick_1hz = 1'b0;
        checks++;
        if (bus.alarm_ring !== 1'b0) begin
            failures++;
            $display("FAIL ring_timeout got=%b exp=0", bus.alarm_ring);
        end
        repeat (3) step();
        checks++;
        if (bus.alarm_ring !== 1'b0) begin
            failures++;
            $display("FAIL ring_held_match got=%b exp=0", bus.alarm_ring);
        end
        bus.alarm_match = 1'b0;
        step();
        bus.alarm_match = 1'b1;
        step();
        press(5'b10000);
        checks++;
        if (bus.alarm_ring !== 1'b0 || bus.alarm_armed !== ALM) begin
            failures++;
            $display("FAIL ring_btn_clear ring=%b armed=%b exp ring=0 armed=%b", bus.alarm_ring, bus.alarm_armed, ALM);
        end
        bus.alarm_match = 1'b0;
        bus.sw_clk_set  = 1'b1;
        step();
        bus.alarm_match = 1'b1;
        step();
        checks++;
        if (bus.alarm_ring !== ALM) begin
            failures++;
            $display("FAIL ring_in_clk_set got=%b exp=%b", bus.alarm_ring, ALM);
        end
        press(5'b00001);
        checks++;
        if (bus.alarm_ring !== 1'b0 || bus.set_inc !== !ALM) begin
            failures++;
            $display("FAIL ring_consume ring=%b inc=%b exp ring=0 inc=%b", bus.alarm_ring, bus.set_inc, !ALM);
        end
        bus.alarm_match = 1'b0;
        bus.sw_clk_set  = 1'b0;
        bus.sw_alm_set  = 1'b1;
        step();
        bus.alarm_match = 1'b1;
        step();
        checks++;
        if (bus.alarm_ring !== 1'b0) begin
            failures++;
            $display("FAIL ring_blocked_alm_set got=%b exp=0", bus.alarm_ring);
        end
        bus.sw_alm_set = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.sw_stopwatch = 1'b1;
        step();
        press(5'b10000);
        press(5'b00001);
        rst = 1'b1;
        bus.btn_pulse = 5'b00010;
        step();
        bus.btn_pulse = '0;
        checks++;
        if (all_outs() !== 11'd0) begin
            failures++;
            $display("FAIL reset_mid got=%b exp=%b", all_outs(), 11'd0);
        end
        rst = 1'b0;
        bus.sw_stopwatch = 1'b0;
        step();
        checks++;
        if (all_outs() !== 11'd0) begin
            failures++;
            $display("FAIL reset_release got=%b exp=%b", all_outs(), 11'd0);
        end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b1;
        bus.sw_clk_set   = 1'b0;
        bus.sw_alm_set   = 1'b0;
        bus.sw_stopwatch = 1'b0;
        bus.btn_pulse    = '0;
        bus.tick_1hz     = 1'b0;
        bus.alarm_match  = 1'b0;
        test_reset();
        test_cursor_wrap();
        test_inc_target();
        test_switch_change();
        test_priority();
        test_stopwatch();
        test_alarm();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mfc_mode_sched.md
# mfc_mode_sched

Mode scheduler for the multi-function clock: owns the single shared button set and 7-segment display and decides, each cycle, which function receives them. The functions are time-of-day, clock set, alarm set and stopwatch. It sits between the button debouncers/edge detectors and the timekeeping, alarm and stopwatch datapaths inside `MFC_top`. It converts switch levels and one-cycle button pulses into a registered mode, a field cursor, and single-cycle command strobes.

## Interface
- `NUM_FIELDS`, 3: number of editable fields in set modes (0 = seconds, 1 = minutes, 2 = hours); legal range 2..4.
- `RING_SEC`, 30: number of `tick_1hz` pulses after which an unacknowledged alarm stops ringing.
- `MCLK  in  1`: main clock (100 MHz); the only clock.
- `RST  in  1`: synchronous, active-high reset.
- `sw_clk_set  in  1`: clock-set switch level, already synchronized.
- `sw_alm_set  in  1`: alarm-set switch level.
- `sw_stopwatch  in  1`: stopwatch-view switch level.
- `btn_pulse  in  5`: debounced one-cycle pulses: [0] up, [1] down, [2] left, [3] right, [4] center.
- `tick_1hz  in  1`: one-cycle pulse per second.
- `alarm_match  in  1`: level, current time equals alarm time.
- `mode  out  2`: 00 NORMAL, 01 CLK_SET, 10 ALM_SET, 11 SW.
- `cursor  out  2`: selected field in set modes.
- `set_inc  out  1`: one-cycle increment strobe for the selected field.
- `set_dec  out  1`: one-cycle decrement strobe for the selected field.
- `set_tgt  out  1`: 0 = clock registers, 1 = alarm registers; valid with strobes.
- `sw_run  out  1`: stopwatch counting enable (level).
- `sw_clear  out  1`: one-cycle stopwatch clear.
- `alarm_armed  out  1`: alarm enabled.
- `alarm_ring  out  1`: alarm output active.

## Operation
- **Reset values:** all outputs are 0 (mode NORMAL, cursor 0, stopwatch stopped, alarm disarmed, not ringing).
- **Mode priority (fixed):** `sw_clk_set` > `sw_alm_set` > `sw_stopwatch` > NORMAL. The target mode is recomputed every cycle from the switch levels. Any mode to any mode is allowed.
- **Mode change:**
  - `mode` takes the target value on the next edge.
  - In the cycle the change is registered, all button pulses are discarded. No strobe is issued for that cycle.
  - Entering CLK_SET or ALM_SET forces `cursor` to 0.
- **Single action per cycle:** when several `btn_pulse` bits are high together, only the highest-priority bit acts. Order is [0] > [1] > [3] > [2] > [4]; the rest are dropped.
- **CLK_SET / ALM_SET:**
  - [0] pulses `set_inc`.
  - [1] pulses `set_dec`.
  - [3] moves `cursor` +1, wrapping from `NUM_FIELDS`-1 to 0.
  - [2] moves `cursor` -1, wrapping from 0 to `NUM_FIELDS`-1.
  - [4] is ignored.
  - `set_tgt` = 0 in CLK_SET, 1 in ALM_SET.
- **SW:**
  - [4] toggles `sw_run`.
  - [1] while `sw_run` = 0 pulses `sw_clear`; [1] while running is ignored.
  - [0], [2] and [3] are ignored.
- **Stopwatch in other modes:** `sw_run` is not changed by leaving SW, so the stopwatch keeps counting in the background.
- **NORMAL:** [4] toggles `alarm_armed`; other buttons are ignored.
- **Alarm:**
  - Ringing starts when `alarm_armed` = 1, `alarm_match` = 1, and mode is not ALM_SET. It is rising-edge detected on `alarm_match`, so a held match does not re-trigger.
  - Ringing clears on any `btn_pulse` in any mode. That pulse is consumed and performs no other action.
  - Ringing also clears after `RING_SEC` `tick_1hz` pulses, or when `alarm_armed` falls.
- **Reset mid-operation:** all state returns to its reset values on the next edge, with no residual strobes.

## Timing
- All outputs are registered.
- A button pulse at edge N produces its strobe or cursor change at edge N+1, lasting exactly one cycle.
- A switch change at edge N updates `mode` at edge N+1. Pulses arriving in cycle N+1 are acted on at N+2 under the new mode.
- `set_inc` and `set_dec` are never high together. `sw_clear` and a `sw_run` toggle never occur in the same cycle.
- Alarm ring timeout: `alarm_ring` falls on the edge after the `RING_SEC`-th `tick_1hz` counted while ringing.

## Configuration
- `MFC_ALARM_EN` defined: full behaviour as above.
- `MFC_ALARM_EN` undefined:
  - The ALM_SET state, ring counter and match-edge detector are not compiled.
  - `sw_alm_set` and `alarm_match` are ignored; priority becomes clock set > stopwatch > NORMAL.
  - `set_tgt`, `alarm_armed` and `alarm_ring` are tied to 0.
  - [4] in NORMAL is ignored.

## Structure
- A shared package `mfc_pkg` holds:
  - the mode encodings (`MODE_NORMAL`, `MODE_CLK_SET`, `MODE_ALM_SET`, `MODE_SW`);
  - the button index constants (`BTN_UP`, `BTN_DOWN`, `BTN_LEFT`, `BTN_RIGHT`, `BTN_CENTER`);
  - the field indices.
- One sub-module, `mfc_alarm_ringer`, contains the match-edge detector, ring flag and second counter. It is instantiated only under `MFC_ALARM_EN`.

## Test plan
- Reset: `RST` high 3 cycles → all outputs 0. Release, then pulse [4] → `alarm_armed` = 1 one cycle later.
- Cursor wrap: `sw_clk_set` = 1, four [3] pulses → `cursor` sequence 1, 2, 0, 1. Then [2] ×2 → 0, 2.
- Increment and target: in CLK_SET, [0] → single-cycle `set_inc` with `set_tgt` = 0. With `sw_alm_set` = 1 and `sw_clk_set` = 0, [1] → `set_dec` with `set_tgt` = 1.
- Stopwatch: `sw_stopwatch` = 1, [4] → `sw_run` = 1. [1] while running → no `sw_clear`. [4] then [1] → `sw_run` = 0 and a one-cycle `sw_clear`. Leave SW while running → `sw_run` stays 1.
- Simultaneous and switch-change: [0] and [3] in the same cycle → only `set_inc`, cursor unchanged. Pulse in the cycle `mode` changes → discarded.
- Alarm: armed, `alarm_match` rises → `alarm_ring` = 1. Then either:
  - 30 `tick_1hz` pulses → ring = 0; or
  - any button → ring = 0, with no other action from that button.
